mem_banked_sdp_clr: RTL and testbench
=====================================

// Module: mem_banked_sdp_clr
// PURPOSE
//  Banked simple-dual-port RAM: NUM_BANKS x DEPTH words, one write port, one read port, single clock.
//  Adds hardware clear sweep (on reset or on request), write-first/read-first collision select,
//  out-of-range protection and a read-valid strobe. Replaces per-bank ad-hoc RAMs for
//  operator/channel register storage.
// PARAMETERS
//  DATA_WIDTH     8   word width, >=1
//  DEPTH          18  words per bank, >=2, need not be a power of two
//  NUM_BANKS      2   bank count, >=1
//  OUTPUT_DELAY   1   read latency in cycles: 0, 1 or 2
//  DEFAULT_VALUE  0   clear/out-of-range word, DATA_WIDTH bits
//  BYPASS         1   1 = write-first on same-index collision, 0 = read-first
//  Derived: AW = $clog2(DEPTH), BW = max(1,$clog2(NUM_BANKS)), N = NUM_BANKS*DEPTH
// PORTS
//  clk        in   1           clock
//  reset_n    in   1           synchronous reset, active-low
//  clear      in   1           start clear sweep (single-cycle pulse sufficient)
//  busy       out  1           1 while clear sweep in progress
//  wea        in   1           write enable
//  bank_a     in   BW          write bank
//  addra      in   AW          write address within bank
//  dia        in   DATA_WIDTH  write data
//  reb        in   1           read enable
//  bank_b     in   BW          read bank
//  addrb      in   AW          read address within bank
//  dob        out  DATA_WIDTH  read data
//  dob_valid  out  1           dob carries data of an accepted read
// BEHAVIOUR
//  - Index = bank*DEPTH + addr. Bank >= NUM_BANKS or addr >= DEPTH is out of range:
//    write dropped, read returns DEFAULT_VALUE (dob_valid still asserted).
//  - FSM {CLEAR, RUN}. reset_n=0 at clk edge -> CLEAR, ptr=0, pipeline flushed.
//    CLEAR: each cycle writes DEFAULT_VALUE at ptr, ptr++; the cycle writing index N-1 moves to
//    RUN. Sweep is exactly N cycles; busy=1 throughout, 0 in RUN.
//    clear=1 in RUN -> CLEAR, ptr=0. clear=1 in CLEAR -> restart, ptr=0.
//  - While busy: wea and reb ignored, dob_valid=0, dob holds.
//  - Accepted write: wea & !busy & in range -> RAM updated at clk edge.
//  - Accepted read: reb & !busy.
//  - OUTPUT_DELAY=0: dob = RAM[index_b] combinationally; dob_valid = reb & !busy.
//  - OUTPUT_DELAY=1: stage1 loads on accepted read, holds otherwise; dob_valid=1 the cycle after
//    an accepted read, else 0.
//  - OUTPUT_DELAY=2: stage2 loads stage1 every cycle; valid pipelined identically (2 cycles).
//  - Collision (accepted write and read, same in-range index, same cycle):
//    BYPASS=1 -> read returns dia; BYPASS=0 -> read returns prior contents.
//  - Reset values: dob=DEFAULT_VALUE, all pipeline stages=DEFAULT_VALUE, dob_valid=0, busy=1.
//  - Reset mid-sweep or mid-read: in-flight reads discarded (no dob_valid), sweep restarts at 0.
//  - Back-to-back reads every cycle sustained: throughput 1 read + 1 write per cycle in RUN.
// TESTING  (DATA_WIDTH=8, DEPTH=18, NUM_BANKS=2, OUTPUT_DELAY=1 unless noted)
//  1 Release reset_n -> busy=1 for exactly 36 cycles, then 0; read all 36 indices -> 0x00, dob_valid each.
//  2 Write bank1/addr5=0xA5, next cycle read bank1/addr5 -> dob=0xA5, dob_valid 1 cycle after reb.
//  3 Index holds 0x11; same cycle write 0x3C + read it -> BYPASS=1: 0x3C; BYPASS=0: 0x11; repeat at delay 0 and 2.
//  4 Write addra=18 data 0xFF -> no RAM change (bank1/addr0 unchanged); read addrb=18 -> 0x00, dob_valid=1.
//  5 Fill RAM, pulse clear -> busy 36 cycles, writes/reads during sweep ignored (dob_valid=0), all reads 0x00 after.
//  6 reset_n low 1 cycle at sweep cycle 10 with read in flight -> no dob_valid, busy exactly 36 cycles after release.

Source files
------------

// File: rtl/mem_banked_sdp_clr.sv
// mem_banked_sdp_clr
//   Banked simple-dual-port RAM holding NUM_BANKS x DEPTH words behind one
//   write port and one read port on a single clock. The array is swept to
//   DEFAULT_VALUE after reset or on a clear request. A parameter selects
//   write-first or read-first behaviour when a read and a write hit the same
//   word. Reads of out-of-range locations return DEFAULT_VALUE, and writes to
//   them are dropped. A valid strobe accompanies every accepted read.
//
// Ports
//   clk        clock
//   reset_n    synchronous reset, active low
//   clear      start a clear sweep (a one-cycle pulse is enough)
//   busy       high while the clear sweep runs; writes and reads are ignored
//   wea        write enable
//   bank_a     write bank
//   addra      write word address within the bank
//   dia        write data
//   reb        read enable
//   bank_b     read bank
//   addrb      read word address within the bank
//   dob        read data, arriving OUTPUT_DELAY cycles after the read
//   dob_valid  dob carries the data of an accepted read
module mem_banked_sdp_clr #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    DEPTH         = 18,
  parameter int                    NUM_BANKS     = 2,
  parameter int                    OUTPUT_DELAY  = 1,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0,
  parameter bit                    BYPASS        = 1'b1,
  localparam int                   AW            = $clog2(DEPTH),
  localparam int                   BW            = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  output logic                  busy,
  input  logic                  wea,
  input  logic [BW-1:0]         bank_a,
  input  logic [AW-1:0]         addra,
  input  logic [DATA_WIDTH-1:0] dia,
  input  logic                  reb,
  input  logic [BW-1:0]         bank_b,
  input  logic [AW-1:0]         addrb,
  output logic [DATA_WIDTH-1:0] dob,
  output logic                  dob_valid
);

  localparam int N  = NUM_BANKS * DEPTH;
  localparam int IW = $clog2(N);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]            state;
  logic [IW-1:0]         ptr;
  logic [DATA_WIDTH-1:0] mem [N];

  logic                  in_range_a;
  logic                  in_range_b;
  logic [IW-1:0]         idx_a;
  logic [IW-1:0]         idx_b;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  collide;
  logic [DATA_WIDTH-1:0] rd_word;

  assign busy = (state == ST_CLEAR);

  // Range checks are done at 32 bits so that a bank field wider than the
  // bank count, or an address field wider than DEPTH, is caught.
  assign in_range_a = (32'(bank_a) < NUM_BANKS) && (32'(addra) < DEPTH);
  assign in_range_b = (32'(bank_b) < NUM_BANKS) && (32'(addrb) < DEPTH);
  assign idx_a      = IW'(32'(bank_a) * DEPTH + 32'(addra));
  assign idx_b      = IW'(32'(bank_b) * DEPTH + 32'(addrb));

  assign wr_acc  = wea & ~busy & in_range_a;
  assign rd_acc  = reb & ~busy;
  assign collide = wr_acc & rd_acc & in_range_b & (idx_a == idx_b);

  // The read word as it must leave the array this cycle. The array itself
  // is still read-first here; write-first forwarding takes dia directly.
  always_comb begin
    rd_word = DEFAULT_VALUE;
    if (in_range_b) begin
      if (BYPASS && collide) rd_word = dia;
      else                   rd_word = mem[idx_b];
    end
  end

  // Sweep sequencer: CLEAR walks ptr over every index, and leaves on the
  // cycle that writes index N-1. A new clear request always restarts at 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else if (clear) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else if (state == ST_CLEAR) begin
      if (ptr == IW'(N - 1)) begin
        state <= ST_RUN;
        ptr   <= '0;
      end else begin
        ptr <= ptr + IW'(1);
      end
    end
  end

  // The single write port is shared between the sweep and user writes.
  // User writes are already blocked while busy.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (busy)        mem[ptr]   <= DEFAULT_VALUE;
      else if (wr_acc) mem[idx_a] <= dia;
    end
  end

  generate
    if (OUTPUT_DELAY == 0) begin : g_comb
      // With zero latency, dob follows the array directly. While busy it
      // shows the last word presented before the sweep started.
      logic [DATA_WIDTH-1:0] hold_reg;

      always_ff @(posedge clk) begin
        if (!reset_n)  hold_reg <= DEFAULT_VALUE;
        else if (!busy) hold_reg <= rd_word;
      end

      assign dob       = busy ? hold_reg : rd_word;
      assign dob_valid = rd_acc;
    end else begin : g_pipe
      // Stage 0 captures only on accepted reads. Later stages shift every
      // cycle, so the valid flag travels with its data.
      logic [DATA_WIDTH-1:0] stage_reg [OUTPUT_DELAY];
      logic [OUTPUT_DELAY-1:0] valid_reg;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          for (int i = 0; i < OUTPUT_DELAY; i++) stage_reg[i] <= DEFAULT_VALUE;
          valid_reg <= '0;
        end else begin
          valid_reg[0] <= rd_acc;
          if (rd_acc) stage_reg[0] <= rd_word;
          for (int i = 1; i < OUTPUT_DELAY; i++) begin
            stage_reg[i] <= stage_reg[i-1];
            valid_reg[i] <= valid_reg[i-1];
          end
        end
      end

      assign dob = stage_reg[OUTPUT_DELAY-1];
      // A read accepted on the cycle a clear is requested would otherwise
      // surface during the sweep. dob_valid stays low for the whole sweep.
      assign dob_valid = valid_reg[OUTPUT_DELAY-1] & ~busy;
    end
  endgenerate

endmodule

// File: tb/tb_mem_banked_sdp_clr.sv
// tb_mem_banked_sdp_clr
//   Drives six instances of mem_banked_sdp_clr with the same stimulus. The
//   instances cover OUTPUT_DELAY 0/1/2 crossed with BYPASS 0/1. A behavioural
//   model (a plain word array, a sweep countdown and latency queues) predicts
//   busy, dob and dob_valid for every instance on every cycle. Directed
//   literal checks pin the model to hand-computed values.
module tb_mem_banked_sdp_clr;

  localparam int NW = 36;   // NUM_BANKS * DEPTH
  localparam int M  = 3;    // index of the OUTPUT_DELAY=1, BYPASS=1 instance

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       wea;
  logic [0:0] bank_a;
  logic [4:0] addra;
  logic [7:0] dia;
  logic       reb;
  logic [0:0] bank_b;
  logic [4:0] addrb;

  logic [7:0] dob_w   [6];
  logic       valid_w [6];
  logic       busy_w  [6];

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  // Instance index = delay*2 + bypass.
  for (genvar gd = 0; gd < 3; gd++) begin : g_d
    for (genvar gb = 0; gb < 2; gb++) begin : g_b
      mem_banked_sdp_clr #(
        .DATA_WIDTH   (8),
        .DEPTH        (18),
        .NUM_BANKS    (2),
        .OUTPUT_DELAY (gd),
        .DEFAULT_VALUE(8'h00),
        .BYPASS       (gb == 1)
      ) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .busy     (busy_w[gd*2+gb]),
        .wea      (wea),
        .bank_a   (bank_a),
        .addra    (addra),
        .dia      (dia),
        .reb      (reb),
        .bank_b   (bank_b),
        .addrb    (addrb),
        .dob      (dob_w[gd*2+gb]),
        .dob_valid(valid_w[gd*2+gb])
      );
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_mem [NW];
  int         sweep_left;             // cycles of sweep still to run
  logic [7:0] m_hold [2];             // delay-0 dob shown while busy
  logic [7:0] m_q1 [2];               // data one cycle after an accepted read
  logic [7:0] m_q2 [2];               // data two cycles after
  logic       m_v1, m_v2;

  // Value an accepted read would see right now, for the given collision policy.
  function automatic logic [7:0] read_val(input int byp);
    bit busy_m, acc_w, acc_r;
    int ia, ib;
    busy_m = (sweep_left > 0);
    if (addrb >= 5'd18) return 8'h00;
    ib    = int'(bank_b) * 18 + int'(addrb);
    ia    = int'(bank_a) * 18 + int'(addra);
    acc_w = wea && !busy_m && (addra < 5'd18);
    acc_r = reb && !busy_m;
    if (byp == 1 && acc_w && acc_r && ia == ib) return dia;
    return m_mem[ib];
  endfunction

  always @(posedge clk) begin
    logic [7:0] r [2];
    bit busy_m, acc_r;
    if (!reset_n) begin
      sweep_left = NW;
      for (int b = 0; b < 2; b++) begin
        m_hold[b] = 8'h00; m_q1[b] = 8'h00; m_q2[b] = 8'h00;
      end
      m_v1 = 1'b0; m_v2 = 1'b0;
    end else begin
      busy_m = (sweep_left > 0);
      acc_r  = reb && !busy_m;
      for (int b = 0; b < 2; b++) r[b] = read_val(b);
      for (int b = 0; b < 2; b++) begin
        if (!busy_m) m_hold[b] = r[b];
        m_q2[b] = m_q1[b];
        if (acc_r) m_q1[b] = r[b];
      end
      m_v2 = m_v1;
      m_v1 = acc_r;
      if (busy_m)                   m_mem[NW - sweep_left] = 8'h00;
      else if (wea && addra < 5'd18) m_mem[int'(bank_a) * 18 + int'(addra)] = dia;
      if (clear)       sweep_left = NW;
      else if (busy_m) sweep_left--;
    end
  end

  // Compare every instance against the model on every falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      bit busy_e, v_e;
      logic [7:0] d_e;
      busy_e = (sweep_left > 0);
      for (int d = 0; d < 3; d++) begin
        for (int b = 0; b < 2; b++) begin
          case (d)
            0: begin
              v_e = reb && !busy_e;
              d_e = busy_e ? m_hold[b] : read_val(b);
            end
            1: begin
              v_e = m_v1 && !busy_e;
              d_e = m_q1[b];
            end
            default: begin
              v_e = m_v2 && !busy_e;
              d_e = m_q2[b];
            end
          endcase
          chk($sformatf("busy d%0d b%0d", d, b), 32'(busy_w[d*2+b]), 32'(busy_e));
          chk($sformatf("valid d%0d b%0d", d, b), 32'(valid_w[d*2+b]), 32'(v_e));
          chk($sformatf("dob d%0d b%0d", d, b), 32'(dob_w[d*2+b]), 32'(d_e));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wea = 1'b0; reb = 1'b0; clear = 1'b0;
  endtask

  task automatic do_write(input int bank, input int addr, input logic [7:0] data);
    wea = 1'b1; bank_a = 1'(bank); addra = 5'(addr); dia = data;
    step();
    wea = 1'b0;
    $display("wr bank=%0d addr=%0d data=%02h", bank, addr, data);
  endtask

  // Count the cycles busy stays high on the main instance (bounded).
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy_w[M] === 1'b1 && cnt < 100) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset_n = 1'b0; idle();
    bank_a = '0; addra = '0; dia = '0; bank_b = '0; addrb = '0;
    for (int i = 0; i < NW; i++) m_mem[i] = 8'h00;

    // Test 1: reset state, then sweep length and cleared contents.
    step();
    check_en = 1'b1;
    chk("reset_busy", 32'(busy_w[M]), 32'd1);
    chk("reset_valid", 32'(valid_w[M]), 32'd0);
    chk("reset_dob", 32'(dob_w[M]), 32'h00);
    reset_n = 1'b1;
    count_busy(cnt);
    chk("reset_sweep_len", 32'(cnt), 32'd36);
    for (int i = 0; i < NW; i++) begin
      reb = 1'b1; bank_b = 1'(i / 18); addrb = 5'(i % 18);
      step();
      chk("clr_read_valid", 32'(valid_w[M]), 32'd1);
      chk("clr_read_dob", 32'(dob_w[M]), 32'h00);
    end
    reb = 1'b0;
    $display("rd all %0d indices after reset sweep", NW);

    // Test 2: write then read back, valid for exactly one cycle.
    do_write(1, 5, 8'hA5);
    reb = 1'b1; bank_b = 1'b1; addrb = 5'd5;
    step();
    reb = 1'b0;
    chk("wr_rd_dob", 32'(dob_w[M]), 32'hA5);
    chk("wr_rd_valid", 32'(valid_w[M]), 32'd1);
    step();
    chk("wr_rd_valid_drop", 32'(valid_w[M]), 32'd0);
    $display("rd bank=1 addr=5 dob=%02h", dob_w[M]);

    // Test 3: same-cycle write and read to one index, at every latency.
    do_write(0, 7, 8'h11);
    wea = 1'b1; bank_a = 1'b0; addra = 5'd7; dia = 8'h3C;
    reb = 1'b1; bank_b = 1'b0; addrb = 5'd7;
    #1;
    chk("coll_d0_byp1", 32'(dob_w[1]), 32'h3C);
    chk("coll_d0_byp0", 32'(dob_w[0]), 32'h11);
    step();
    idle();
    chk("coll_d1_byp1", 32'(dob_w[3]), 32'h3C);
    chk("coll_d1_byp0", 32'(dob_w[2]), 32'h11);
    step();
    chk("coll_d2_byp1", 32'(dob_w[5]), 32'h3C);
    chk("coll_d2_byp0", 32'(dob_w[4]), 32'h11);
    chk("coll_d2_valid", 32'(valid_w[4]), 32'd1);
    $display("collision bank=0 addr=7 wr=3c old=11");

    // Test 4: out-of-range write must not alias onto bank1/addr0.
    do_write(1, 0, 8'h5A);
    do_write(0, 18, 8'hFF);
    reb = 1'b1; bank_b = 1'b0; addrb = 5'd18;
    step();
    chk("oor_read_dob", 32'(dob_w[M]), 32'h00);
    chk("oor_read_valid", 32'(valid_w[M]), 32'd1);
    bank_b = 1'b1; addrb = 5'd0;
    step();
    reb = 1'b0;
    chk("oor_no_alias", 32'(dob_w[M]), 32'h5A);
    $display("oor write bank=0 addr=18 dropped");

    // Test 5: fill, clear sweep with traffic ignored, then all zero.
    for (int i = 0; i < NW; i++) do_write(i / 18, i % 18, 8'((i * 7) + 1));
    clear = 1'b1;
    step();
    clear = 1'b0;
    cnt = 0;
    while (busy_w[M] === 1'b1 && cnt < 100) begin
      chk("sweep_no_valid", 32'(valid_w[M]), 32'd0);
      cnt++;
      wea = 1'b1; bank_a = 1'(cnt % 2); addra = 5'(cnt % 18); dia = 8'hEE;
      reb = 1'b1; bank_b = 1'(cnt % 2); addrb = 5'(cnt % 18);
      step();
    end
    idle();
    chk("clear_sweep_len", 32'(cnt), 32'd36);
    for (int i = 0; i < NW; i++) begin
      reb = 1'b1; bank_b = 1'(i / 18); addrb = 5'(i % 18);
      step();
      chk("clear_read_dob", 32'(dob_w[M]), 32'h00);
    end
    reb = 1'b0;
    $display("clear sweep done, %0d indices read back", NW);

    // Test 6a: reset with a read in flight in the two-stage pipeline.
    do_write(0, 3, 8'h77);
    reb = 1'b1; bank_b = 1'b0; addrb = 5'd3;
    step();
    reb = 1'b0; reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("rst_flush_d2", 32'(valid_w[5]), 32'd0);
    chk("rst_flush_d1", 32'(valid_w[M]), 32'd0);
    count_busy(cnt);
    chk("rst_flush_sweep_len", 32'(cnt), 32'd36);
    $display("reset with read in flight");

    // Test 6b: reset at sweep cycle 10 restarts the full sweep.
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (10) step();
    reset_n = 1'b0; reb = 1'b1;
    step();
    reset_n = 1'b1; reb = 1'b0;
    chk("midsweep_no_valid", 32'(valid_w[M]), 32'd0);
    count_busy(cnt);
    chk("midsweep_sweep_len", 32'(cnt), 32'd36);
    reb = 1'b1; bank_b = 1'b1; addrb = 5'd5;
    step();
    reb = 1'b0;
    chk("midsweep_read_dob", 32'(dob_w[M]), 32'h00);
    chk("midsweep_read_valid", 32'(valid_w[M]), 32'd1);
    $display("reset mid-sweep");

    step();
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
